uart_rx_sampler: RTL and testbench

- UART receiver. Deserialises the asynchronous RxD line into bytes.
- Runs on the oversampling strobe Tick from the team's baud-rate generator, set to N x bit rate (default 16x).
- Validates the start bit at mid-bit and checks the stop bit.
- Delivers each byte as a one-cycle valid pulse to the host-side logic of the UART_232 block.

---
 rtl/uart_rx_sampler.sv | 147 ++++++++++++++
 tb/tb_uart_rx_sampler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with mid-bit start check, stop check and break hold-off
// Optional feature macro UART_RX_PARITY_EN adds a parity bit (ParityOdd in, ParityErr out).
// Ports: Clk, Rst_n (async, active-low) | Tick oversampling strobe | RxD serial line (idle high)
//        RxData last good byte | RxValid, FrameErr one-cycle pulses | Busy = not idle
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic                 RxD,
`ifdef UART_RX_PARITY_EN
  input  logic                 ParityOdd,
  output logic                 ParityErr,
`endif
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 FrameErr,
  output logic                 Busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0] BLAST = 3'(DATA_BITS - 1);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4,
    BREAK = 3'd5
  } state_e;
  state_e state_q, state_d;
  logic meta_q, rx_s_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d, perr_q, perr_d;
`endif
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      {rx_s_q, meta_q} <= 2'b11;
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      {rx_s_q, meta_q} <= {meta_q, RxD};
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q <= pbad_d;
      perr_q <= perr_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d = pbad_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (Tick && !rx_s_q) begin
        state_d = START;
        tick_d = '0;
      end
      // start bit must still be low half a bit later, otherwise it was a glitch
      START: if (Tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == HALF) begin
          state_d = rx_s_q ? IDLE : DATA;
          tick_d = '0;
          bit_d = '0;
        end
      end
      DATA: if (Tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == LAST) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          tick_d = '0;
          bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == BLAST) state_d = PARITY;
`else
          if (bit_q == BLAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (Tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == LAST) begin
          pbad_d = (^shift_q ^ rx_s_q) != ParityOdd;
          tick_d = '0;
          state_d = STOP;
        end
      end
`endif
      // a low stop bit parks in BREAK so a held-low line cannot retrigger frames
      STOP: if (Tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == LAST) begin
          tick_d = '0;
          state_d = rx_s_q ? IDLE : BREAK;
          valid_d = rx_s_q;
          ferr_d = !rx_s_q;
          data_d = rx_s_q ? shift_q : data_q;
`ifdef UART_RX_PARITY_EN
          perr_d = rx_s_q & pbad_q;
`endif
        end
      end
      BREAK: state_d = rx_s_q ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  assign RxData = data_q;
  assign RxValid = valid_q;
  assign FrameErr = ferr_q;
  assign Busy = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign ParityErr = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames against an event-queue model of expected pulses, data and timing
module tb_uart_rx_sampler;
  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1 + (DB + 2) * OS + OS / 2;
`else
  localparam int LAT = 1 + (DB + 1) * OS + OS / 2;
`endif
  typedef struct {
    bit ferr;
    bit perr;
    logic [DB-1:0] data;
    int at;
  } ev_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b1;
  logic Tick = 1'b0;
  logic RxD = 1'b1;
  logic ParityOdd = 1'b0;
  logic ParityErr;
  logic [DB-1:0] RxData;
  logic RxValid, FrameErr, Busy;
  ev_t q[$];
  int tick_idx = 0;
  int n_cmp = 0, n_bad = 0, n_valid = 0, n_ferr = 0;
  logic [DB-1:0] m_data = '0;
  uart_rx_sampler #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Tick(Tick),
    .RxD(RxD),
`ifdef UART_RX_PARITY_EN
    .ParityOdd(ParityOdd),
    .ParityErr(ParityErr),
`endif
    .RxData(RxData),
    .RxValid(RxValid),
    .FrameErr(FrameErr),
    .Busy(Busy)
  );
`ifndef UART_RX_PARITY_EN
  assign ParityErr = 1'b0;
`endif
  always #5 Clk = ~Clk;
  initial forever begin
    repeat (3) @(negedge Clk);
    Tick = 1'b1;
    @(negedge Clk);
    Tick = 1'b0;
  end
  always @(posedge Clk) if (Tick) tick_idx <= tick_idx + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (tick %0d)", name, act, exp, tick_idx);
    end
  endtask
  always @(negedge Clk) begin : cmp
    ev_t e;
    logic exp_perr;
    exp_perr = 1'b0;
    if (!Rst_n) begin
      q.delete();
      m_data = '0;
      chk("rst_data", 32'(RxData), 0);
      chk("rst_valid", 32'(RxValid), 0);
      chk("rst_ferr", 32'(FrameErr), 0);
      chk("rst_busy", 32'(Busy), 0);
    end else begin
      chk("valid_ferr_excl", 32'(RxValid & FrameErr), 0);
      if (RxValid || FrameErr) begin
        chk("pulse_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pulse_kind_ferr", 32'(FrameErr), 32'(e.ferr));
          chk("pulse_tick", tick_idx, e.at);
          exp_perr = RxValid & e.perr;
          if (RxValid) begin
            n_valid++;
            m_data = e.data;
          end else n_ferr++;
        end
      end else if (q.size() != 0 && tick_idx > q[0].at) begin
        chk("missing_pulse", 32'(RxValid | FrameErr), 1);
        void'(q.pop_front());
      end
      chk("parity_err", 32'(ParityErr), 32'(exp_perr));
      chk("rxdata_hold", 32'(RxData), 32'(m_data));
    end
  end
  task automatic tk(input int n);
    repeat (n) begin
      do @(posedge Clk); while (!Tick);
    end
    #1;
  endtask
  task automatic drive(input logic v, input int n);
    RxD = v;
    tk(n);
  endtask
  task automatic send(input logic [DB-1:0] d, input logic stop, input logic par = 1'b0);
    ev_t e;
    e.at = tick_idx + LAT;
    e.data = d;
    e.ferr = !stop;
    e.perr = stop && ((^d ^ par) != ParityOdd);
    q.push_back(e);
    drive(1'b0, OS);
    for (int i = 0; i < DB; i++) drive(d[i], OS);
`ifdef UART_RX_PARITY_EN
    drive(par, OS);
`endif
    drive(stop, OS);
  endtask
  initial begin
    #1 Rst_n = 1'b0;
    tk(2);
    Rst_n = 1'b1;
    tk(4);
    chk("busy_idle", 32'(Busy), 0);
    send(8'h55, 1'b1);
    chk("busy_after_55", 32'(Busy), 0);
    chk("count_55", n_valid, 1);
    chk("data_55", 32'(RxData), 32'h55);
    send(8'hA3, 1'b1);
    chk("data_a3", 32'(RxData), 32'hA3);
    send(8'h00, 1'b1);
    chk("count_b2b", n_valid, 3);
    chk("data_00", 32'(RxData), 32'h00);
    drive(1'b0, 4);
    chk("busy_glitch", 32'(Busy), 1);
    drive(1'b1, 8);
    chk("busy_glitch_end", 32'(Busy), 0);
    chk("count_glitch", n_valid + n_ferr, 3);
    send(8'h3C, 1'b0);
    drive(1'b0, 20 * OS);
    chk("busy_break", 32'(Busy), 1);
    chk("ferr_count", n_ferr, 1);
    chk("data_after_ferr", 32'(RxData), 32'h00);
    drive(1'b1, OS);
    chk("busy_break_exit", 32'(Busy), 0);
    send(8'h81, 1'b1);
    chk("count_81", n_valid, 4);
    chk("data_81", 32'(RxData), 32'h81);
    drive(1'b0, OS);
    drive(1'b1, 3 * OS);
    chk("busy_mid_ff", 32'(Busy), 1);
    Rst_n = 1'b0;
    tk(3);
    Rst_n = 1'b1;
    tk(4);
    chk("busy_after_rst", 32'(Busy), 0);
    send(8'h12, 1'b1);
    chk("count_12", n_valid, 5);
    chk("data_12", 32'(RxData), 32'h12);
`ifdef UART_RX_PARITY_EN
    ParityOdd = 1'b0;
    send(8'h07, 1'b1, 1'b0);
    send(8'h07, 1'b1, 1'b1);
    chk("data_07", 32'(RxData), 32'h07);
    send(8'hF0, 1'b0, 1'b1);
    drive(1'b1, OS);
    chk("ferr_par", n_ferr, 2);
    ParityOdd = 1'b1;
    send(8'h01, 1'b1, 1'b0);
    chk("count_par", n_valid, 8);
`endif
    tk(2 * OS);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
